// File: rtl/int_div_iterative.sv
// Multi-cycle restoring integer divider (one quotient bit per cycle) with val/rdy
// request/response handshakes and a per-transaction security domain label.
module int_div_iterative #(
  parameter int p_nbits = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               domain,
  input  logic               req_val,
  output logic               req_rdy,
  input  logic [p_nbits-1:0] req_a,
  input  logic [p_nbits-1:0] req_b,
  input  logic               req_signed,
  output logic               resp_val,
  input  logic               resp_rdy,
  output logic               resp_domain,
  output logic [p_nbits-1:0] resp_quot,
  output logic [p_nbits-1:0] resp_rem
);

  localparam int cw = $clog2(p_nbits + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             state, state_nxt;
  logic [cw-1:0]      counter;
  logic [p_nbits-1:0] dvd, dvs, rem;
  logic [p_nbits-1:0] a_abs, b_abs, rem_sub, rem_nxt;
  logic [p_nbits:0]   rem_shift;
  logic               ge, neg_q, neg_r, accept;

  // Magnitudes fit the unsigned datapath; -MIN wraps to 2^(p_nbits-1), the right magnitude.
  assign a_abs = (req_signed && req_a[p_nbits-1]) ? -req_a : req_a;
  assign b_abs = (req_signed && req_b[p_nbits-1]) ? -req_b : req_b;

  // Shifted partial remainder needs one extra bit before the compare.
  assign rem_shift = {rem, dvd[p_nbits-1]};
  assign ge        = rem_shift >= {1'b0, dvs};
  assign rem_sub   = rem_shift[p_nbits-1:0] - dvs;
  assign rem_nxt   = ge ? rem_sub : rem_shift[p_nbits-1:0];

  // Control depends only on state, counter and handshakes, never on operand values.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    req_rdy   = 1'b0;
    resp_val  = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        req_rdy = reset_n;
        accept  = req_val && reset_n;
        if (accept) state_nxt = CALC;
      end
      CALC: begin
        if (counter == cw'(1)) state_nxt = DONE;
      end
      DONE: begin
        resp_val = 1'b1;
        if (resp_rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state is written with non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state       <= IDLE;
      counter     <= '0;
      dvd         <= '0;
      dvs         <= '0;
      rem         <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      resp_domain <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            dvd         <= a_abs;
            dvs         <= b_abs;
            rem         <= '0;
            counter     <= cw'(p_nbits);
            // Divide-by-zero keeps the all-ones quotient un-negated.
            neg_q       <= req_signed && (req_a[p_nbits-1] ^ req_b[p_nbits-1]) && (|req_b);
            neg_r       <= req_signed && req_a[p_nbits-1];
            resp_domain <= domain;
          end
        end
        CALC: begin
          dvd     <= {dvd[p_nbits-2:0], ge};
          rem     <= rem_nxt;
          counter <= counter - cw'(1);
        end
        default: ;
      endcase
    end
  end

  assign resp_quot = neg_q ? -dvd : dvd;
  assign resp_rem  = neg_r ? -rem : rem;

endmodule

// File: tb/tb_int_div_iterative.sv
// Self-checking bench for int_div_iterative: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_int_div_iterative;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset_n, domain, req_val, req_rdy, req_signed;
  logic         resp_val, resp_rdy, resp_domain;
  logic [W-1:0] req_a, req_b, resp_quot, resp_rem;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  int_div_iterative #(.p_nbits(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .domain     (domain),
    .req_val    (req_val),
    .req_rdy    (req_rdy),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_signed (req_signed),
    .resp_val   (resp_val),
    .resp_rdy   (resp_rdy),
    .resp_domain(resp_domain),
    .resp_quot  (resp_quot),
    .resp_rem   (resp_rem)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division, truncating toward zero, with the
  // divide-by-zero rule layered on top.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    longint sa, sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Entered and left at a negedge with req_rdy expected high.
  task automatic run_txn(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input logic dom, input logic [W-1:0] eq, input logic [W-1:0] er,
                         input int hold, input string tag);
    int cycles;
    check({tag, ".req_rdy_idle"}, W'(req_rdy), W'(1));
    req_val    = 1'b1;
    req_a      = a;
    req_b      = b;
    req_signed = s;
    domain     = dom;
    @(posedge clk);
    @(negedge clk);
    req_val    = 1'b0;
    req_a      = $urandom;
    req_b      = $urandom;
    req_signed = 1'($urandom);
    domain     = ~dom;
    check({tag, ".req_rdy_calc"}, W'(req_rdy), W'(0));
    cycles = 0;
    while (!resp_val && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
    check({tag, ".latency"}, W'(cycles), W'(W));
    check({tag, ".quot"}, resp_quot, eq);
    check({tag, ".rem"}, resp_rem, er);
    check({tag, ".domain"}, W'(resp_domain), W'(dom));
    check({tag, ".req_rdy_done"}, W'(req_rdy), W'(0));
    for (int i = 0; i < hold; i++) begin
      domain = 1'($urandom);
      @(negedge clk);
      check({tag, ".hold_val"}, W'(resp_val), W'(1));
      check({tag, ".hold_quot"}, resp_quot, eq);
      check({tag, ".hold_rem"}, resp_rem, er);
      check({tag, ".hold_domain"}, W'(resp_domain), W'(dom));
      check({tag, ".hold_rdy"}, W'(req_rdy), W'(0));
    end
    resp_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_rdy = 1'b0;
    check({tag, ".val_after"}, W'(resp_val), W'(0));
    check({tag, ".rdy_after"}, W'(req_rdy), W'(1));
    check({tag, ".domain_after"}, W'(resp_domain), W'(dom));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] a, b, eq, er;
    logic         s;
    reset_n    = 1'b0;
    domain     = 1'b0;
    req_val    = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_signed = 1'b0;
    resp_rdy   = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.req_rdy", W'(req_rdy), W'(0));
    check("reset.resp_val", W'(resp_val), W'(0));
    check("reset.quot", resp_quot, '0);
    check("reset.rem", resp_rem, '0);
    check("reset.domain", W'(resp_domain), W'(0));
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(32'd100, 32'd7, 1'b0, 1'b0, 32'd14, 32'd2, 0, "u100_7");
    run_txn(32'hFFFF_FFF9, 32'd2, 1'b1, 1'b0, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0, "s-7_2");
    run_txn(32'd7, 32'hFFFF_FFFE, 1'b1, 1'b1, 32'hFFFF_FFFD, 32'd1, 0, "s7_-2");
    run_txn(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 32'h7FFF_FFFC, 32'd1, 0, "u_big_2");
    run_txn(32'd1234, 32'd0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1234, 0, "u_div0");
    run_txn(32'hFFFF_FF00, 32'd0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FF00, 0, "s_div0_neg");
    run_txn(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'h8000_0000, 32'd0, 0, "s_ovf");
    run_txn(32'h8000_0000, 32'd3, 1'b1, 1'b1, 32'hD555_5556, 32'hFFFF_FFFE, 0, "s_min_3");
    run_txn(32'd500, 32'd13, 1'b0, 1'b1, 32'd38, 32'd6, 10, "backpressure");
    run_txn(32'd77, 32'd8, 1'b0, 1'b1, 32'd9, 32'd5, 0, "dom1");
    run_txn(32'd77, 32'd8, 1'b0, 1'b0, 32'd9, 32'd5, 0, "dom0_b2b");

    // Reset in the middle of CALC discards the in-flight result.
    req_val    = 1'b1;
    req_a      = 32'd1000;
    req_b      = 32'd3;
    req_signed = 1'b0;
    domain     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_val = 1'b0;
    repeat (9) @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst.req_rdy_low", W'(req_rdy), W'(0));
    check("midrst.resp_val", W'(resp_val), W'(0));
    check("midrst.quot", resp_quot, '0);
    check("midrst.rem", resp_rem, '0);
    check("midrst.domain", W'(resp_domain), W'(0));
    reset_n = 1'b1;
    #1;
    check("midrst.req_rdy", W'(req_rdy), W'(1));
    @(negedge clk);
    run_txn(32'd45, 32'd9, 1'b0, 1'b0, 32'd5, 32'd0, 0, "after_rst");

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = W'($urandom_range(1, 255));
        2:       b = -W'($urandom_range(1, 255));
        default: b = ($urandom_range(0, 2) == 0) ? '0 : W'($urandom_range(1, 65535));
      endcase
      s = 1'($urandom);
      model(a, b, s, eq, er);
      run_txn(a, b, s, 1'($urandom), eq, er, $urandom_range(0, 3), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
